// File: rtl/seg_scan_sched.sv
// Scan scheduler for a 6-digit multiplexed seven-segment display.
// Keeps double-buffered digit data (shadow and active), steps one digit
// per scan period and decodes it into a {seg, sel} word. Each word goes
// to the 74HC595 serializer over a req/ack handshake. Shadow data moves
// into the active set only at a frame boundary, so a frame never shows
// a mix of old and new data.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-low
//   en         scan enable
//   data_in    six 4-bit digit codes, digit0 = [3:0]
//   point_in   decimal point per digit, 1 = lit
//   blank_in   per-digit blank, 1 = dark
//   load       strobe, captures data/point/blank into shadow
//   tx_req     word valid to serializer
//   tx_data    {seg[7:0], sel[5:0]}, seg active-low, sel one-hot
//   tx_ack     serializer done pulse
//   cur_dig    digit index of current/last word
//   frame_done pulse after the digit-5 ack
//   overrun    pulse when a scan tick arrives while awaiting ack
//
// state     | meaning
// ----------+---------------------------------------------------
// IDLE      | scan stopped, cur_dig parked at 0, timer held
// WAIT_TICK | waiting for the scan tick to issue the next digit
// WAIT_ACK  | word requested, waiting for serializer ack
// BLANK     | sending one all-dark word before returning to IDLE

module seg_scan_sched #(
  parameter int SCAN_CNT = 50000,
  parameter int TIMER_W  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] data_in,
  input  logic [5:0]  point_in,
  input  logic [5:0]  blank_in,
  input  logic        load,
  output logic        tx_req,
  output logic [13:0] tx_data,
  input  logic        tx_ack,
  output logic [2:0]  cur_dig,
  output logic        frame_done,
  output logic        overrun
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_TICK = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
  localparam logic [1:0] ST_BLANK     = 2'd3;

  localparam logic [TIMER_W-1:0] TC = TIMER_W'(SCAN_CNT - 1);

  logic [1:0]         state;
  logic [TIMER_W-1:0] timer;
  logic               tick;

  logic [23:0] act_data, sh_data;
  logic [5:0]  act_point, sh_point;
  logic [5:0]  act_blank, sh_blank;
  logic        pending;

  logic [3:0]  cur_code;
  logic        cur_point;
  logic        cur_blank;
  logic [7:0]  hex_seg;
  logic [7:0]  seg_word;
  logic [5:0]  sel_word;
  logic [2:0]  nxt_dig;

  assign tick    = (timer == TC);
  assign nxt_dig = (cur_dig == 3'd5) ? 3'd0 : cur_dig + 3'd1;

  always_comb begin
    cur_code  = 4'h0;
    cur_point = 1'b0;
    cur_blank = 1'b0;
    case (cur_dig)
      3'd0: begin cur_code = act_data[3:0];   cur_point = act_point[0]; cur_blank = act_blank[0]; end
      3'd1: begin cur_code = act_data[7:4];   cur_point = act_point[1]; cur_blank = act_blank[1]; end
      3'd2: begin cur_code = act_data[11:8];  cur_point = act_point[2]; cur_blank = act_blank[2]; end
      3'd3: begin cur_code = act_data[15:12]; cur_point = act_point[3]; cur_blank = act_blank[3]; end
      3'd4: begin cur_code = act_data[19:16]; cur_point = act_point[4]; cur_blank = act_blank[4]; end
      3'd5: begin cur_code = act_data[23:20]; cur_point = act_point[5]; cur_blank = act_blank[5]; end
      default: ;
    endcase
  end

  // Common-anode, active-low: seg[7] = dp, seg[6:0] = g..a.
  always_comb begin
    hex_seg = 8'hFF;
    case (cur_code)
      4'h0: hex_seg = 8'hC0;
      4'h1: hex_seg = 8'hF9;
      4'h2: hex_seg = 8'hA4;
      4'h3: hex_seg = 8'hB0;
      4'h4: hex_seg = 8'h99;
      4'h5: hex_seg = 8'h92;
      4'h6: hex_seg = 8'h82;
      4'h7: hex_seg = 8'hF8;
      4'h8: hex_seg = 8'h80;
      4'h9: hex_seg = 8'h90;
      4'hA: hex_seg = 8'h88;
      4'hB: hex_seg = 8'h83;
      4'hC: hex_seg = 8'hC6;
      4'hD: hex_seg = 8'hA1;
      4'hE: hex_seg = 8'h86;
      4'hF: hex_seg = 8'h8E;
      default: hex_seg = 8'hFF;
    endcase
  end

  always_comb begin
    seg_word = hex_seg;
    if (cur_point) seg_word[7] = 1'b0;
    // blank wins over the decimal point
    if (cur_blank) seg_word = 8'hFF;
    sel_word = 6'b000001 << cur_dig;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      timer      <= '0;
      tx_req     <= 1'b0;
      tx_data    <= '0;
      cur_dig    <= 3'd0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      act_data   <= '0;
      act_point  <= '0;
      act_blank  <= 6'h3F;
      sh_data    <= '0;
      sh_point   <= '0;
      sh_blank   <= 6'h3F;
      pending    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;

      // Timer stays at 0 while parked so the first digit lands one full
      // scan period after the scan is enabled.
      if (state == ST_IDLE || !en) begin
        timer <= '0;
      end else if (tick) begin
        timer <= '0;
      end else begin
        timer <= timer + TIMER_W'(1);
      end

      if (load) begin
        sh_data  <= data_in;
        sh_point <= point_in;
        sh_blank <= blank_in;
        pending  <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          cur_dig <= 3'd0;
          tx_req  <= 1'b0;
          if (load) begin
            act_data  <= data_in;
            act_point <= point_in;
            act_blank <= blank_in;
          end
          if (en) state <= ST_WAIT_TICK;
        end

        ST_WAIT_TICK: begin
          if (!en) begin
            state <= ST_BLANK;
          end else if (tick) begin
            tx_data <= {seg_word, sel_word};
            tx_req  <= 1'b1;
            state   <= ST_WAIT_ACK;
          end
        end

        ST_WAIT_ACK: begin
          // the serializer is too slow for this tick; drop it
          if (tick) overrun <= 1'b1;
          if (tx_ack) begin
            tx_req  <= 1'b0;
            cur_dig <= nxt_dig;
            state   <= en ? ST_WAIT_TICK : ST_BLANK;
            if (cur_dig == 3'd5) begin
              frame_done <= 1'b1;
              if (pending) begin
                act_data  <= sh_data;
                act_point <= sh_point;
                act_blank <= sh_blank;
                // a load in this same cycle keeps pending for the next frame
                if (!load) pending <= 1'b0;
              end
            end
          end
        end

        ST_BLANK: begin
          if (!tx_req) begin
            tx_req  <= 1'b1;
            tx_data <= {8'hFF, 6'b000000};
          end else if (tx_ack) begin
            tx_req  <= 1'b0;
            cur_dig <= 3'd0;
            state   <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_sched.sv
// Directed testbench for seg_scan_sched with SCAN_CNT = 25.
module tb_seg_scan_sched;

  localparam int SCAN = 25;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [23:0] data_in = '0;
  logic [5:0]  point_in = '0;
  logic [5:0]  blank_in = '0;
  logic        load = 1'b0;
  logic        tx_ack = 1'b0;
  logic        tx_req;
  logic [13:0] tx_data;
  logic [2:0]  cur_dig;
  logic        frame_done;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  seg_scan_sched #(.SCAN_CNT(SCAN), .TIMER_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .point_in(point_in),
    .blank_in(blank_in), .load(load), .tx_req(tx_req), .tx_data(tx_data),
    .tx_ack(tx_ack), .cur_dig(cur_dig), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] w(input logic [7:0] s, input int d);
    logic [5:0] sel;
    sel = 6'(1 << d);
    return {s, sel};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_req && n < maxc);
    chk("req_seen", {31'd0, tx_req}, 32'd1);
  endtask

  task automatic word_req(input string tag, input logic [7:0] s, input int d);
    int n;
    wait_req(60, n);
    chk(tag, {18'd0, tx_data}, {18'd0, w(s, d)});
    chk("cur_dig_at_req", {29'd0, cur_dig}, d);
  endtask

  task automatic ack(input int dly);
    repeat (dly) @(negedge clk);
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
  endtask

  task automatic word_ack(input int d);
    ack(2);
    chk("req_drop_after_ack", {31'd0, tx_req}, 32'd0);
    chk("frame_done_after_ack", {31'd0, frame_done}, (d == 5) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int n;
    int r0;
    int r1;
    int ovr;
    int ov_at;
    int bad;
    int hi;
    logic [7:0] seg_a [6];
    seg_a = '{8'hC0, 8'hF9, 8'h24, 8'hB0, 8'h99, 8'h8E};

    // Reset and dark start
    repeat (10) @(negedge clk);
    chk("rst_tx_req", {31'd0, tx_req}, 32'd0);
    chk("rst_tx_data", {18'd0, tx_data}, 32'd0);
    chk("rst_cur_dig", {29'd0, cur_dig}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b1;
    en  = 1'b1;
    wait_req(40, n);
    chk("first_req_latency", n, 32'd26);
    r0 = cyc;
    chk("dark_d0", {18'd0, tx_data}, {18'd0, w(8'hFF, 0)});
    word_ack(0);
    // ack while waiting for a tick must be ignored
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    chk("stray_ack_cur_dig", {29'd0, cur_dig}, 32'd1);
    chk("stray_ack_no_req", {31'd0, tx_req}, 32'd0);
    word_req("dark_d1", 8'hFF, 1);
    chk("slot_spacing", cyc - r0, SCAN);
    word_ack(1);
    for (int d = 2; d < 6; d++) begin
      word_req("dark_word", 8'hFF, d);
      word_ack(d);
    end
    @(negedge clk);
    chk("frame_done_one_cycle", {31'd0, frame_done}, 32'd0);

    // Decode frame, loaded while IDLE
    rst = 1'b0;
    en  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    data_in  = 24'hF43210;
    point_in = 6'b000100;
    blank_in = 6'b000000;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    en   = 1'b1;
    for (int d = 0; d < 6; d++) begin
      word_req("decode_word", seg_a[d], d);
      word_ack(d);
    end

    // Tear-free update: load during the digit-2 slot of the next frame
    for (int d = 0; d < 3; d++) begin
      word_req("frame2_word", seg_a[d], d);
      if (d == 2) begin
        data_in  = 24'h999999;
        point_in = 6'b000000;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        ack(1);
        chk("req_drop_after_ack", {31'd0, tx_req}, 32'd0);
      end else begin
        word_ack(d);
      end
    end
    for (int d = 3; d < 6; d++) begin
      word_req("old_data_kept", seg_a[d], d);
      word_ack(d);
    end
    word_req("new_frame_d0", 8'h90, 0);
    word_ack(0);

    // Overrun: hold off the digit-1 ack for 30 cycles
    word_req("ovr_d1", 8'h90, 1);
    r1 = cyc;
    ovr = 0;
    ov_at = -1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (overrun) begin
        ovr++;
        ov_at = cyc - r1;
      end
      if (tx_data !== w(8'h90, 1) || tx_req !== 1'b1 || cur_dig !== 3'd1) bad++;
    end
    chk("overrun_count", ovr, 32'd1);
    chk("overrun_at_tick", ov_at, SCAN);
    chk("held_during_overrun", bad, 32'd0);
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    chk("ovr_ack_drop", {31'd0, tx_req}, 32'd0);
    chk("ovr_ack_cur_dig", {29'd0, cur_dig}, 32'd2);
    word_req("after_ovr_d2", 8'h90, 2);
    chk("after_ovr_timing", cyc - r1, 2 * SCAN);
    word_ack(2);

    // Disable while awaiting the digit-3 ack
    word_req("dis_d3", 8'h90, 3);
    en = 1'b0;
    word_ack(3);
    chk("dis_cur_dig", {29'd0, cur_dig}, 32'd4);
    @(negedge clk);
    chk("blank_req", {31'd0, tx_req}, 32'd1);
    chk("blank_word", {18'd0, tx_data}, {18'd0, 8'hFF, 6'b000000});
    ack(2);
    chk("blank_ack_drop", {31'd0, tx_req}, 32'd0);
    chk("idle_cur_dig", {29'd0, cur_dig}, 32'd0);
    hi = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_req) hi++;
    end
    chk("idle_no_req", hi, 32'd0);
    chk("idle_timer", 32'(dut.timer), 32'd0);

    // Reset in the middle of a handshake
    en = 1'b1;
    word_req("pre_rst_d0", 8'h90, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx_req", {31'd0, tx_req}, 32'd0);
    chk("mid_rst_tx_data", {18'd0, tx_data}, 32'd0);
    chk("mid_rst_cur_dig", {29'd0, cur_dig}, 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_rst_hold_req", {31'd0, tx_req}, 32'd0);
    chk("mid_rst_overrun", {31'd0, overrun}, 32'd0);

    // Point and blank priority
    en  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    data_in  = 24'h000000;
    point_in = 6'b000011;
    blank_in = 6'b000010;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    en   = 1'b1;
    word_req("point_d0", 8'h40, 0);
    word_ack(0);
    word_req("blank_over_point_d1", 8'hFF, 1);
    word_ack(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_sched.md
Name: seg_scan_sched

Overview:
- Scan scheduler for the 6-digit dynamic seven-segment display.
- Holds the digit values, steps one digit per scan period, and decodes each digit into a 14-bit {seg, sel} word.
- Hands each word to the 74HC595 serializer (the block driving stcp/shcp/DS/OE) over a req/ack handshake.
- Sits between display-data producers and the serializer. It paces the serializer and enforces tear-free frame updates.

Parameters:
- SCAN_CNT, 50000, clock cycles per digit slot (1 ms at 50 MHz). Minimum value 4.
- TIMER_W, 16, scan timer width. Requires SCAN_CNT-1 < 2^TIMER_W.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous reset, active-low
- en  in  1  scan enable
- data_in  in  24  six 4-bit digit codes; digit0 = [3:0], digit5 = [23:20]
- point_in  in  6  decimal point per digit, 1 = lit
- blank_in  in  6  per-digit blank, 1 = digit dark
- load  in  1  one-cycle strobe that captures data_in/point_in/blank_in into shadow registers
- tx_req  out  1  word valid to serializer
- tx_data  out  14  {seg[7:0], sel[5:0]}
- tx_ack  in  1  serializer done, one-cycle pulse
- cur_dig  out  3  digit index of the current/last word, 0..5
- frame_done  out  1  one-cycle pulse after the digit-5 ack
- overrun  out  1  one-cycle pulse when a scan tick lands while awaiting ack

Behaviour:
- Reset is synchronous on rst==0 and overrides everything:
  - tx_req=0, tx_data=0, cur_dig=0, frame_done=0, overrun=0, timer=0
  - active and shadow data/point = 0, active and shadow blank = 6'h3F (display dark)
  - pending flag = 0, FSM = IDLE
- Scan timer:
  - Counts 0..SCAN_CNT-1 and wraps to 0 while en=1; held at 0 while FSM is IDLE with en=0.
  - tick = (timer == SCAN_CNT-1).
- FSM states: IDLE, WAIT_TICK, WAIT_ACK, BLANK.
  - IDLE: en=1 -> WAIT_TICK. cur_dig=0.
  - WAIT_TICK:
    - On tick, register tx_data for cur_dig and set tx_req=1 on the next edge (1-cycle latency from tick) -> WAIT_ACK.
    - en=0 -> BLANK.
  - WAIT_ACK:
    - tx_req and tx_data held stable until tx_ack is sampled high. tx_req is 0 the cycle after ack.
    - On ack, cur_dig advances 0..5 and wraps to 0.
    - On the 5->0 wrap: frame_done=1 for one cycle. If pending=1, shadow copies to active and pending clears in that same cycle.
    - After ack: en=1 -> WAIT_TICK; en=0 -> BLANK.
    - tick while in WAIT_ACK: overrun=1 for one cycle and the tick is discarded. The next word is sent on the first tick after the ack.
    - tx_ack outside WAIT_ACK/BLANK-send is ignored.
  - BLANK:
    - Sends one word {8'hFF, 6'b000000} immediately (no tick wait) using the same req/ack rules.
    - On ack: cur_dig=0 -> IDLE.
    - en is not sampled again until IDLE.
- Word build:
  - sel = one-hot, bit cur_dig = 1.
  - seg is common-anode active-low, seg[7]=dp, seg[6:0]=g..a.
  - Digit codes 0..F map to C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
  - If point set, seg[7]=0.
  - If blank set, seg=8'hFF (overrides point).
- Load:
  - load=1 captures the inputs into shadow and sets pending.
  - A later load before the frame boundary overwrites shadow (last load wins).
  - load coincident with the boundary transfer: the new values go to shadow, pending stays 1, and they apply at the next boundary.
  - While IDLE, load copies directly to active as well.
- A reset during WAIT_ACK drops tx_req on that edge. The serializer must tolerate an abandoned request.

Test Plan:
- All tests use SCAN_CNT=25, tx_ack pulsed 3 cycles after tx_req rises unless stated.
- Reset/dark start: rst=0 for 10 cycles -> all outputs 0. Release with en=1 and no load -> tx_req rises at cycle 26 after release with tx_data={FF,000001}. Subsequent words are {FF,000010}... {FF,100000}, then frame_done pulses.
- Decode: in IDLE, load data_in=24'hF43210, point_in=6'b000100, blank_in=0, then en=1 -> words in order:
  - {C0,000001}
  - {F9,000010}
  - {24,000100}
  - {B0,001000}
  - {99,010000}
  - {8E,100000}
  - frame_done one cycle after the last ack.
- Tear-free update: during the digit-2 slot, load data_in=24'h999999 -> digits 3..5 keep the old codes. Next frame digit0 = {90,000001}.
- Overrun: withhold tx_ack 30 cycles on digit 1 -> overrun pulses once at the tick, tx_data unchanged, cur_dig stays 1. The digit-2 word is issued 1 cycle after the first tick following the ack.
- Disable mid-transaction: drop en while awaiting digit-3 ack -> after the ack, {FF,000000} is requested, then IDLE with cur_dig=0 and the timer held at 0.
- Reset mid-handshake: rst=0 while tx_req=1 -> tx_req=0 at the next edge, and all reset values hold.
